c2_line_master: RTL and testbench
=================================

Name: c2_line_master

Overview:
- Cache-side master for bus 2, the line-granular link between the cache and main memory.
- Accepts one line request at a time from the cache controller: a fill (read) or an eviction write-back (write).
- Runs the C2 command/response protocol on the shared tri-state cmd/data wires and serialises or deserialises the line into LINE_BYTES/BUS_BYTES beats.
- Returns the assembled line or write completion to the cache controller.

Parameters:
- LINE_BYTES, 16, cache line size in bytes; must be a multiple of BUS_BYTES.
- BUS_BYTES, 2, bus-2 data width in bytes.
- ADDR_W, 14, line address width (tag+set bits); drives the bus-2 address wires.
- BEATS, LINE_BYTES/BUS_BYTES, derived; data beats per line.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  cache controller presents a request.
- req_ready  out  1  block idle; request accepted at posedge when req_valid&&req_ready.
- req_write  in  1  1=write line, 0=read line.
- req_addr  in  ADDR_W  line address.
- req_data  in  LINE_BYTES*8  line to write; byte k at bits [8k+7:8k].
- resp_valid  out  1  one-cycle pulse: read data valid or write acknowledged.
- resp_data  out  LINE_BYTES*8  assembled read line; holds until next read completes.
- c2_addr  out  ADDR_W  bus-2 address.
- c2_data  inout  BUS_BYTES*8  bus-2 data; driven only while the block owns the bus.
- c2_cmd  inout  2  bus-2 command; encoding NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3.

Behaviour:
- Reset (async):
  - State IDLE; block owns the bus with c2_cmd=NOP, c2_data=0, c2_addr=0.
  - req_ready=1, resp_valid=0, resp_data=0, beat counter=0.
  - Any in-flight transfer is abandoned; no resp_valid is issued for it.
- Bus ownership: c2_cmd and c2_data are driven when own=1, else high-Z. own changes only on posedge. The block never drives while the memory owns the bus.
- Request capture: at acceptance, addr, write flag and line are registered; req_ready falls the same edge. Later changes to req_* are ignored.
- IDLE: drive NOP. On accept, go to RD_CMD if read, WR_DATA if write.
- RD_CMD:
  - Drive c2_cmd=READ_LINE and c2_addr for exactly one cycle.
  - At the next posedge, set own=0 and go to RD_WAIT.
- RD_WAIT:
  - Bus released. Sample c2_cmd each posedge.
  - At the first posedge with c2_cmd==RESPONSE, capture beat 0 into bytes [0..BUS_BYTES-1] and go to RD_DATA.
  - Any other value, including NOP or X/Z, means keep waiting.
- RD_DATA:
  - Capture beat i at each of the next BEATS-1 posedges; beat i fills bytes [i*BUS_BYTES +: BUS_BYTES].
  - After the last beat: set own=1 (drive NOP), resp_valid=1 for one cycle with the final line, then IDLE.
- WR_DATA:
  - Drive c2_cmd=WRITE_LINE, c2_addr, and beat i on c2_data for BEATS consecutive cycles, beat 0 in the first cycle.
  - cmd is held WRITE_LINE throughout.
  - At the posedge ending beat BEATS-1, set own=0 and go to WR_WAIT.
- WR_WAIT:
  - Bus released.
  - At the first posedge with c2_cmd==RESPONSE: set own=1 (drive NOP), pulse resp_valid for one cycle, then IDLE. resp_data is unchanged.
- req_ready returns to 1 in the same cycle resp_valid is high. A new request may be accepted on that edge, giving back-to-back operation with no idle cycle.
- c2_addr holds the last request address between transactions.
- No timeout; waiting states last indefinitely until RESPONSE arrives.
- Read latency, counting the cycle RESPONSE is first sampled as T: resp_valid is high in cycle T+BEATS.
- Write latency: resp_valid is high one cycle after RESPONSE is sampled.

Test Plan:
- Read: addr 0x005; slave answers after 100 cycles with beats 0x0100, 0x0302, ..., 0x0F0E (8 beats) -> resp_valid pulses once, 8 cycles after RESPONSE is first sampled; resp_data=0x0F0E0D0C0B0A09080706050403020100; c2_cmd=READ_LINE for exactly 1 cycle.
- Write: addr 0x3FFF, req_data bytes k=0xA0+k -> slave sees WRITE_LINE for 8 consecutive posedges with beats 0xA1A0, 0xA3A2, ..., 0xAFAE; block releases the bus; slave RESPONSE after 90 cycles -> resp_valid one cycle later; then c2_cmd=NOP, driven by the block.
- Back-to-back: write then read with req_valid held high -> second request accepted on the resp_valid edge; req_ready=0 throughout both transfers; req_data changes during a transfer are not reflected on the bus.
- Contention: across the read/write sequences, c2_cmd and c2_data are never X (no double drive), and are Z only while the slave owns the bus.
- Reset mid-read in RD_WAIT -> immediately c2_cmd=NOP driven, req_ready=1, no resp_valid; the next read completes normally.
- Slave RESPONSE held off 5000 cycles -> block stays in RD_WAIT; req_ready=0; no spurious resp_valid.

Source files
------------

// File: rtl/c2_line_master.sv
// Cache-side bus-2 master: moves one cache line per request over the shared
// tri-state C2 cmd/data wires as BEATS little-endian data beats.
module c2_line_master #(
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned BUS_BYTES  = 2,
    parameter int unsigned ADDR_W     = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LINE_BYTES*8-1:0] req_data,
    output logic                    resp_valid,
    output logic [LINE_BYTES*8-1:0] resp_data,
    output logic [ADDR_W-1:0]       c2_addr,
    inout  wire  [BUS_BYTES*8-1:0]  c2_data,
    inout  wire  [1:0]              c2_cmd
);

    localparam int unsigned BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int unsigned BUS_W  = BUS_BYTES * 8;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [1:0] CMD_NOP        = 2'd0;
    localparam logic [1:0] CMD_RESPONSE   = 2'd1;
    localparam logic [1:0] CMD_READ_LINE  = 2'd2;
    localparam logic [1:0] CMD_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StRdWait,
        StRdData,
        StWrData,
        StWrWait
    } state_e;

    state_e              state_q, state_d;
    logic                own_q, own_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_valid_q, resp_valid_d;

    logic                req_fire;
    logic                cmd_is_resp;
    logic [LINE_W-1:0]   rd_line;
    logic [BUS_W-1:0]    wr_beat;
    logic [1:0]          cmd_out;
    logic [BUS_W-1:0]    data_out;

    assign req_ready   = (state_q == StIdle);
    assign req_fire    = req_valid && req_ready;
    assign cmd_is_resp = (c2_cmd == CMD_RESPONSE);

    // Line buffer with the beat currently on the bus merged in at the beat index.
    always_comb begin
        rd_line = line_q;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_q == BEAT_W'(i)) begin
                rd_line[i*BUS_W +: BUS_W] = c2_data;
            end
        end
    end

    always_comb begin
        wr_beat = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_q == BEAT_W'(i)) begin
                wr_beat = line_q[i*BUS_W +: BUS_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        line_d       = line_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    addr_d  = req_addr;
                    line_d  = req_data;
                    beat_d  = '0;
                    state_d = req_write ? StWrData : StRdCmd;
                end
            end
            StRdCmd: begin
                own_d   = 1'b0;
                state_d = StRdWait;
            end
            StRdWait, StRdData: begin
                // Beat 0 is qualified by RESPONSE; later beats follow back to back.
                if (state_q == StRdData || cmd_is_resp) begin
                    line_d = rd_line;
                    if (beat_q == LAST_BEAT) begin
                        own_d        = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_data_d  = rd_line;
                        beat_d       = '0;
                        state_d      = StIdle;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = StRdData;
                    end
                end
            end
            StWrData: begin
                if (beat_q == LAST_BEAT) begin
                    own_d   = 1'b0;
                    beat_d  = '0;
                    state_d = StWrWait;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            StWrWait: begin
                if (cmd_is_resp) begin
                    own_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                own_d   = 1'b1;
                beat_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cmd_out  = CMD_NOP;
        data_out = '0;
        unique case (state_q)
            StRdCmd: begin
                cmd_out = CMD_READ_LINE;
            end
            StWrData: begin
                cmd_out  = CMD_WRITE_LINE;
                data_out = wr_beat;
            end
            default: begin
                cmd_out  = CMD_NOP;
                data_out = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            own_q        <= 1'b1;
            beat_q       <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Bus wires float whenever memory owns the bus.
    assign c2_cmd  = own_q ? cmd_out : 'z;
    assign c2_data = own_q ? data_out : 'z;

    assign c2_addr    = addr_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_c2_line_master.sv
// Self-checking bench for c2_line_master: table of line transactions against a
// bus-2 slave model, plus back-to-back, reset-abort and long hold-off sequences.
module tb_c2_line_master;

    localparam int AW    = 14;
    localparam int BW    = 16;
    localparam int LW    = 128;
    localparam int BEATS = 8;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] RDL  = 2'd2;
    localparam logic [1:0] WRL  = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_data;
    logic          resp_valid;
    logic [LW-1:0] resp_data;
    logic [AW-1:0] c2_addr;
    wire  [BW-1:0] c2_data;
    wire  [1:0]    c2_cmd;

    logic          s_en;
    logic [1:0]    s_cmd;
    logic [BW-1:0] s_data;

    int            n_vec = 0;
    int            n_err = 0;
    int            rv_count = 0;
    logic [LW-1:0] sb[$];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        int            delay;
        logic [LW-1:0] exp_resp;
    } vec_t;

    vec_t vt[5];

    always #5 clk = ~clk;

    assign c2_cmd  = s_en ? s_cmd : 2'bzz;
    assign c2_data = s_en ? s_data : {BW{1'bz}};

    c2_line_master dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .c2_addr    (c2_addr),
        .c2_data    (c2_data),
        .c2_cmd     (c2_cmd)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every resp_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            rv_count++;
            chk("resp_expected", LW'(sb.size() != 0), LW'(1));
            if (sb.size() != 0) begin
                chk("resp_data", resp_data, sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_read(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                            input logic [LW-1:0] exp, input int delay, input bit pre);
        int rv0;
        if (!pre) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = addr;
            req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            sb.push_back(exp);
        end
        chk("rd_ready_idle", LW'(req_ready), LW'(1));
        tick();
        req_valid = 1'b0;
        rv0 = rv_count;
        chk("rd_cmd", LW'(c2_cmd), LW'(RDL));
        chk("rd_addr", LW'(c2_addr), LW'(addr));
        chk("rd_ready_busy", LW'(req_ready), LW'(0));
        tick();
        chk("rd_cmd_one_cycle", LW'(c2_cmd !== RDL), LW'(1));
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i % 1000 == 999) begin
                chk("rd_wait_ready", LW'(req_ready), LW'(0));
                chk("rd_wait_no_resp", LW'(rv_count), LW'(rv0));
            end
        end
        chk("rd_wait_ready_end", LW'(req_ready), LW'(0));
        s_en   = 1'b1;
        s_cmd  = RESP;
        s_data = line[0 +: BW];
        for (int i = 1; i < BEATS; i++) begin
            tick();
            chk("rd_bus_slave", LW'(c2_data), LW'(s_data));
            chk("rd_latency_early", LW'(resp_valid), LW'(0));
            s_cmd  = NOP;
            s_data = line[i*BW +: BW];
        end
        tick();
        chk("rd_resp_valid", LW'(resp_valid), LW'(1));
        chk("rd_ready_at_resp", LW'(req_ready), LW'(1));
        s_en = 1'b0;
        #1;
        chk("rd_cmd_nop_after", LW'(c2_cmd), LW'(NOP));
        tick();
        chk("rd_resp_pulse", LW'(resp_valid), LW'(0));
        chk("rd_resp_count", LW'(rv_count), LW'(rv0 + 1));
        chk("rd_resp_hold", resp_data, exp);
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                             input int delay, input logic [LW-1:0] exp, input bit b2b,
                             input logic [AW-1:0] nxt_addr, input logic [LW-1:0] nxt_exp);
        int rv0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_data  = line;
        sb.push_back(exp);
        chk("wr_ready_idle", LW'(req_ready), LW'(1));
        tick();
        if (b2b) begin
            // Next request is presented early; it must not disturb the write in flight.
            req_write = 1'b0;
            req_addr  = nxt_addr;
            req_data  = ~line;
            sb.push_back(nxt_exp);
        end else begin
            req_valid = 1'b0;
        end
        rv0 = rv_count;
        for (int i = 0; i < BEATS; i++) begin
            chk("wr_cmd", LW'(c2_cmd), LW'(WRL));
            chk("wr_beat", LW'(c2_data), LW'(line[i*BW +: BW]));
            chk("wr_addr", LW'(c2_addr), LW'(addr));
            chk("wr_ready_busy", LW'(req_ready), LW'(0));
            tick();
        end
        chk("wr_released", LW'(c2_cmd !== WRL), LW'(1));
        for (int i = 0; i < delay; i++) begin
            tick();
        end
        chk("wr_wait_ready", LW'(req_ready), LW'(0));
        chk("wr_wait_no_resp", LW'(rv_count), LW'(rv0));
        s_en   = 1'b1;
        s_cmd  = RESP;
        s_data = 16'h5A5A;
        tick();
        chk("wr_resp_valid", LW'(resp_valid), LW'(1));
        chk("wr_ready_at_resp", LW'(req_ready), LW'(1));
        s_en = 1'b0;
        #1;
        chk("wr_cmd_nop_after", LW'(c2_cmd), LW'(NOP));
        if (!b2b) begin
            tick();
            chk("wr_resp_pulse", LW'(resp_valid), LW'(0));
            chk("wr_resp_count", LW'(rv_count), LW'(rv0 + 1));
        end
    endtask

    initial begin
        logic [LW-1:0] l5;
        logic [LW-1:0] l6;
        logic [LW-1:0] l7;
        int            rv0;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        s_en      = 1'b0;
        s_cmd     = NOP;
        s_data    = '0;

        #2;
        chk("rst_cmd", LW'(c2_cmd), LW'(NOP));
        chk("rst_data", LW'(c2_data), LW'(0));
        chk("rst_addr", LW'(c2_addr), LW'(0));
        chk("rst_ready", LW'(req_ready), LW'(1));
        chk("rst_resp_valid", LW'(resp_valid), LW'(0));
        chk("rst_resp_data", resp_data, LW'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();

        vt[0] = '{1'b0, 14'h0005, 128'h0F0E0D0C0B0A09080706050403020100, 100,
                  128'h0F0E0D0C0B0A09080706050403020100};
        vt[1] = '{1'b1, 14'h3FFF, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 90,
                  128'h0F0E0D0C0B0A09080706050403020100};
        vt[2] = '{1'b0, 14'h02A5, 128'hDEADBEEFCAFEF00D13579BDF2468ACE0, 3,
                  128'hDEADBEEFCAFEF00D13579BDF2468ACE0};
        vt[3] = '{1'b1, 14'h0000, 128'h0123456789ABCDEFFEDCBA9876543210, 0,
                  128'hDEADBEEFCAFEF00D13579BDF2468ACE0};
        vt[4] = '{1'b0, 14'h1234, 128'hFFFF0000FFFF0000A5A55A5A00FF00FF, 1,
                  128'hFFFF0000FFFF0000A5A55A5A00FF00FF};

        for (int v = 0; v < 5; v++) begin
            if (vt[v].wr) begin
                run_write(vt[v].addr, vt[v].line, vt[v].delay, vt[v].exp_resp, 1'b0, '0, '0);
            end else begin
                run_read(vt[v].addr, vt[v].line, vt[v].exp_resp, vt[v].delay, 1'b0);
            end
        end

        // Back-to-back write then read with req_valid held high throughout.
        l5 = 128'h1111222233334444555566667777_8888;
        l6 = 128'h8421_4218_2184_1842_C3C3_3C3C_9696_6969;
        run_write(14'h00AA, l5, 7, vt[4].exp_resp, 1'b1, 14'h0155, l6);
        run_read(14'h0155, l6, l6, 2, 1'b1);

        // Reset while waiting for the read response abandons the transfer.
        l7 = 128'h0102030405060708090A0B0C0D0E0F10;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 14'h00F0;
        req_data  = '0;
        sb.push_back(l7);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        rv0 = rv_count;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_cmd", LW'(c2_cmd), LW'(NOP));
        chk("mid_rst_data", LW'(c2_data), LW'(0));
        chk("mid_rst_addr", LW'(c2_addr), LW'(0));
        chk("mid_rst_ready", LW'(req_ready), LW'(1));
        chk("mid_rst_resp_data", resp_data, LW'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_no_resp", LW'(rv_count), LW'(rv0));
        run_read(14'h00F1, l7, l7, 4, 1'b0);

        // Long hold-off: nothing may happen until the slave finally answers.
        run_read(14'h3000, vt[0].line, vt[0].line, 5000, 1'b0);

        chk("sb_drained", LW'(sb.size()), LW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
